// File: rtl/cl_pcim_ost_limiter.sv
// Outstanding-burst limiter and drain controller in front of the PCIM output slice.
// Define CL_PCIM_OST_STATS_EN to add the command/stall statistics counters.
module cl_pcim_ost_limiter #(
  parameter int MAX_WR_OST = 32,
  parameter int MAX_RD_OST = 64
) (
  input  logic         aclk,
  input  logic         aresetn,
  // s_pcim: upstream traffic generator
  input  logic [15:0]  s_pcim_awid,
  input  logic [63:0]  s_pcim_awaddr,
  input  logic [7:0]   s_pcim_awlen,
  input  logic [2:0]   s_pcim_awsize,
  input  logic         s_pcim_awvalid,
  output logic         s_pcim_awready,
  input  logic [511:0] s_pcim_wdata,
  input  logic [63:0]  s_pcim_wstrb,
  input  logic         s_pcim_wlast,
  input  logic         s_pcim_wvalid,
  output logic         s_pcim_wready,
  output logic [15:0]  s_pcim_bid,
  output logic [1:0]   s_pcim_bresp,
  output logic         s_pcim_bvalid,
  input  logic         s_pcim_bready,
  input  logic [15:0]  s_pcim_arid,
  input  logic [63:0]  s_pcim_araddr,
  input  logic [7:0]   s_pcim_arlen,
  input  logic [2:0]   s_pcim_arsize,
  input  logic         s_pcim_arvalid,
  output logic         s_pcim_arready,
  output logic [15:0]  s_pcim_rid,
  output logic [511:0] s_pcim_rdata,
  output logic [1:0]   s_pcim_rresp,
  output logic         s_pcim_rlast,
  output logic         s_pcim_rvalid,
  input  logic         s_pcim_rready,
  // m_pcim: toward the output register slice
  output logic [15:0]  m_pcim_awid,
  output logic [63:0]  m_pcim_awaddr,
  output logic [7:0]   m_pcim_awlen,
  output logic [2:0]   m_pcim_awsize,
  output logic         m_pcim_awvalid,
  input  logic         m_pcim_awready,
  output logic [511:0] m_pcim_wdata,
  output logic [63:0]  m_pcim_wstrb,
  output logic         m_pcim_wlast,
  output logic         m_pcim_wvalid,
  input  logic         m_pcim_wready,
  input  logic [15:0]  m_pcim_bid,
  input  logic [1:0]   m_pcim_bresp,
  input  logic         m_pcim_bvalid,
  output logic         m_pcim_bready,
  output logic [15:0]  m_pcim_arid,
  output logic [63:0]  m_pcim_araddr,
  output logic [7:0]   m_pcim_arlen,
  output logic [2:0]   m_pcim_arsize,
  output logic         m_pcim_arvalid,
  input  logic         m_pcim_arready,
  input  logic [15:0]  m_pcim_rid,
  input  logic [511:0] m_pcim_rdata,
  input  logic [1:0]   m_pcim_rresp,
  input  logic         m_pcim_rlast,
  input  logic         m_pcim_rvalid,
  output logic         m_pcim_rready,
  // control / status
  input  logic         drain_req,
  output logic         drained,
  output logic [7:0]   wr_ost,
  output logic [7:0]   rd_ost,
  output logic [2:0]   err_sticky,
  input  logic         err_clr
`ifdef CL_PCIM_OST_STATS_EN
  ,
  output logic [31:0]  wr_cmd_cnt,
  output logic [31:0]  rd_cmd_cnt,
  output logic [31:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {ACTIVE, DRAIN, DRAINED} state_t;
  state_t state;

  logic aw_en, ar_en;
  logic aw_hs, ar_hs, b_hs, r_hs, rl_hs;
  logic [2:0] err_set;

  // Gates depend only on registered state, never on downstream ready.
  assign aw_en = (wr_ost < 8'(MAX_WR_OST)) && (state == ACTIVE);
  assign ar_en = (rd_ost < 8'(MAX_RD_OST)) && (state == ACTIVE);

  assign m_pcim_awid    = s_pcim_awid;
  assign m_pcim_awaddr  = s_pcim_awaddr;
  assign m_pcim_awlen   = s_pcim_awlen;
  assign m_pcim_awsize  = s_pcim_awsize;
  assign m_pcim_awvalid = s_pcim_awvalid & aw_en;
  assign s_pcim_awready = m_pcim_awready & aw_en;

  assign m_pcim_arid    = s_pcim_arid;
  assign m_pcim_araddr  = s_pcim_araddr;
  assign m_pcim_arlen   = s_pcim_arlen;
  assign m_pcim_arsize  = s_pcim_arsize;
  assign m_pcim_arvalid = s_pcim_arvalid & ar_en;
  assign s_pcim_arready = m_pcim_arready & ar_en;

  assign m_pcim_wdata   = s_pcim_wdata;
  assign m_pcim_wstrb   = s_pcim_wstrb;
  assign m_pcim_wlast   = s_pcim_wlast;
  assign m_pcim_wvalid  = s_pcim_wvalid;
  assign s_pcim_wready  = m_pcim_wready;

  assign s_pcim_bid     = m_pcim_bid;
  assign s_pcim_bresp   = m_pcim_bresp;
  assign s_pcim_bvalid  = m_pcim_bvalid;
  assign m_pcim_bready  = s_pcim_bready;

  assign s_pcim_rid     = m_pcim_rid;
  assign s_pcim_rdata   = m_pcim_rdata;
  assign s_pcim_rresp   = m_pcim_rresp;
  assign s_pcim_rlast   = m_pcim_rlast;
  assign s_pcim_rvalid  = m_pcim_rvalid;
  assign m_pcim_rready  = s_pcim_rready;

  assign aw_hs = s_pcim_awvalid & aw_en & m_pcim_awready;
  assign ar_hs = s_pcim_arvalid & ar_en & m_pcim_arready;
  assign b_hs  = m_pcim_bvalid & s_pcim_bready;
  assign r_hs  = m_pcim_rvalid & s_pcim_rready;
  assign rl_hs = r_hs & m_pcim_rlast;

  assign err_set = {(b_hs && wr_ost == 8'd0) || (rl_hs && rd_ost == 8'd0),
                    r_hs && (m_pcim_rresp != 2'b00),
                    b_hs && (m_pcim_bresp != 2'b00)};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ost     <= 8'd0;
      rd_ost     <= 8'd0;
      err_sticky <= 3'b000;
    end else begin
      // Completions at zero count are flagged via err_set and never wrap.
      if (aw_hs && !b_hs)
        wr_ost <= wr_ost + 8'd1;
      else if (b_hs && !aw_hs && wr_ost != 8'd0)
        wr_ost <= wr_ost - 8'd1;
      if (ar_hs && !rl_hs)
        rd_ost <= rd_ost + 8'd1;
      else if (rl_hs && !ar_hs && rd_ost != 8'd0)
        rd_ost <= rd_ost - 8'd1;
      err_sticky <= (err_clr ? 3'b000 : err_sticky) | err_set;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ACTIVE;
      drained <= 1'b0;
    end else begin
      drained <= (state == DRAINED);
      case (state)
        ACTIVE:
          if (drain_req) begin
            // A command accepted this cycle still counts as outstanding.
            if (wr_ost == 8'd0 && rd_ost == 8'd0 && !aw_hs && !ar_hs)
              state <= DRAINED;
            else
              state <= DRAIN;
          end
        DRAIN:
          if (!drain_req)
            state <= ACTIVE;
          else if (wr_ost == 8'd0 && rd_ost == 8'd0)
            state <= DRAINED;
        DRAINED:
          if (!drain_req)
            state <= ACTIVE;
        default:
          state <= ACTIVE;
      endcase
    end
  end

`ifdef CL_PCIM_OST_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_cmd_cnt <= 32'd0;
      rd_cmd_cnt <= 32'd0;
      stall_cnt  <= 32'd0;
    end else if (err_clr) begin
      wr_cmd_cnt <= 32'd0;
      rd_cmd_cnt <= 32'd0;
      stall_cnt  <= 32'd0;
    end else begin
      wr_cmd_cnt <= wr_cmd_cnt + {31'd0, aw_hs};
      rd_cmd_cnt <= rd_cmd_cnt + {31'd0, ar_hs};
      stall_cnt  <= stall_cnt +
                    {31'd0, (s_pcim_awvalid & ~aw_en) | (s_pcim_arvalid & ~ar_en)};
    end
  end
`endif

endmodule

// File: tb/tb_cl_pcim_ost_limiter.sv
// Directed + randomized bench for cl_pcim_ost_limiter against a counting reference model.
module tb_cl_pcim_ost_limiter;
  localparam int MAXW = 4;
  localparam int MAXR = 5;

  logic aclk, aresetn;
  logic [15:0]  s_pcim_awid, s_pcim_arid, s_pcim_bid, s_pcim_rid;
  logic [63:0]  s_pcim_awaddr, s_pcim_araddr, s_pcim_wstrb;
  logic [7:0]   s_pcim_awlen, s_pcim_arlen;
  logic [2:0]   s_pcim_awsize, s_pcim_arsize;
  logic         s_pcim_awvalid, s_pcim_awready, s_pcim_arvalid, s_pcim_arready;
  logic [511:0] s_pcim_wdata, s_pcim_rdata;
  logic         s_pcim_wlast, s_pcim_wvalid, s_pcim_wready;
  logic [1:0]   s_pcim_bresp, s_pcim_rresp;
  logic         s_pcim_bvalid, s_pcim_bready, s_pcim_rlast, s_pcim_rvalid, s_pcim_rready;
  logic [15:0]  m_pcim_awid, m_pcim_arid, m_pcim_bid, m_pcim_rid;
  logic [63:0]  m_pcim_awaddr, m_pcim_araddr, m_pcim_wstrb;
  logic [7:0]   m_pcim_awlen, m_pcim_arlen;
  logic [2:0]   m_pcim_awsize, m_pcim_arsize;
  logic         m_pcim_awvalid, m_pcim_awready, m_pcim_arvalid, m_pcim_arready;
  logic [511:0] m_pcim_wdata, m_pcim_rdata;
  logic         m_pcim_wlast, m_pcim_wvalid, m_pcim_wready;
  logic [1:0]   m_pcim_bresp, m_pcim_rresp;
  logic         m_pcim_bvalid, m_pcim_bready, m_pcim_rlast, m_pcim_rvalid, m_pcim_rready;
  logic         drain_req, drained, err_clr;
  logic [7:0]   wr_ost, rd_ost;
  logic [2:0]   err_sticky;
`ifdef CL_PCIM_OST_STATS_EN
  logic [31:0]  wr_cmd_cnt, rd_cmd_cnt, stall_cnt;
`endif

  cl_pcim_ost_limiter #(.MAX_WR_OST(MAXW), .MAX_RD_OST(MAXR)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_pcim_awid(s_pcim_awid), .s_pcim_awaddr(s_pcim_awaddr), .s_pcim_awlen(s_pcim_awlen),
    .s_pcim_awsize(s_pcim_awsize), .s_pcim_awvalid(s_pcim_awvalid), .s_pcim_awready(s_pcim_awready),
    .s_pcim_wdata(s_pcim_wdata), .s_pcim_wstrb(s_pcim_wstrb), .s_pcim_wlast(s_pcim_wlast),
    .s_pcim_wvalid(s_pcim_wvalid), .s_pcim_wready(s_pcim_wready),
    .s_pcim_bid(s_pcim_bid), .s_pcim_bresp(s_pcim_bresp), .s_pcim_bvalid(s_pcim_bvalid),
    .s_pcim_bready(s_pcim_bready),
    .s_pcim_arid(s_pcim_arid), .s_pcim_araddr(s_pcim_araddr), .s_pcim_arlen(s_pcim_arlen),
    .s_pcim_arsize(s_pcim_arsize), .s_pcim_arvalid(s_pcim_arvalid), .s_pcim_arready(s_pcim_arready),
    .s_pcim_rid(s_pcim_rid), .s_pcim_rdata(s_pcim_rdata), .s_pcim_rresp(s_pcim_rresp),
    .s_pcim_rlast(s_pcim_rlast), .s_pcim_rvalid(s_pcim_rvalid), .s_pcim_rready(s_pcim_rready),
    .m_pcim_awid(m_pcim_awid), .m_pcim_awaddr(m_pcim_awaddr), .m_pcim_awlen(m_pcim_awlen),
    .m_pcim_awsize(m_pcim_awsize), .m_pcim_awvalid(m_pcim_awvalid), .m_pcim_awready(m_pcim_awready),
    .m_pcim_wdata(m_pcim_wdata), .m_pcim_wstrb(m_pcim_wstrb), .m_pcim_wlast(m_pcim_wlast),
    .m_pcim_wvalid(m_pcim_wvalid), .m_pcim_wready(m_pcim_wready),
    .m_pcim_bid(m_pcim_bid), .m_pcim_bresp(m_pcim_bresp), .m_pcim_bvalid(m_pcim_bvalid),
    .m_pcim_bready(m_pcim_bready),
    .m_pcim_arid(m_pcim_arid), .m_pcim_araddr(m_pcim_araddr), .m_pcim_arlen(m_pcim_arlen),
    .m_pcim_arsize(m_pcim_arsize), .m_pcim_arvalid(m_pcim_arvalid), .m_pcim_arready(m_pcim_arready),
    .m_pcim_rid(m_pcim_rid), .m_pcim_rdata(m_pcim_rdata), .m_pcim_rresp(m_pcim_rresp),
    .m_pcim_rlast(m_pcim_rlast), .m_pcim_rvalid(m_pcim_rvalid), .m_pcim_rready(m_pcim_rready),
    .drain_req(drain_req), .drained(drained), .wr_ost(wr_ost), .rd_ost(rd_ost),
    .err_sticky(err_sticky), .err_clr(err_clr)
`ifdef CL_PCIM_OST_STATS_EN
    , .wr_cmd_cnt(wr_cmd_cnt), .rd_cmd_cnt(rd_cmd_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int checks = 0;
  int passes = 0;

  // reference model: 0 = active, 1 = draining, 2 = drained
  int mw, mr, mst;
  logic [2:0] merr;
  logic mdrained;
  int unsigned mwc, mrc, msc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic mreset();
    mw = 0; mr = 0; mst = 0; merr = 3'b000; mdrained = 1'b0;
    mwc = 0; mrc = 0; msc = 0;
  endtask

  task automatic idle();
    s_pcim_awvalid = 0; s_pcim_arvalid = 0; s_pcim_wvalid = 0; s_pcim_wlast = 0;
    s_pcim_bready = 1; s_pcim_rready = 1;
    m_pcim_awready = 1; m_pcim_arready = 1; m_pcim_wready = 1;
    m_pcim_bvalid = 0; m_pcim_bresp = 0; m_pcim_rvalid = 0; m_pcim_rresp = 0; m_pcim_rlast = 0;
    drain_req = 0; err_clr = 0;
  endtask

  task automatic rand_payload();
    s_pcim_awid = 16'($urandom); s_pcim_awaddr = {$urandom, $urandom};
    s_pcim_awlen = 8'($urandom); s_pcim_awsize = 3'($urandom);
    s_pcim_arid = 16'($urandom); s_pcim_araddr = {$urandom, $urandom};
    s_pcim_arlen = 8'($urandom); s_pcim_arsize = 3'($urandom);
    s_pcim_wstrb = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) begin
      s_pcim_wdata[i*32 +: 32] = $urandom;
      m_pcim_rdata[i*32 +: 32] = $urandom;
    end
    m_pcim_bid = 16'($urandom); m_pcim_rid = 16'($urandom);
  endtask

  // One clock: check combinational gating, advance model, check registered state.
  task automatic tick();
    bit awen, aren, awhs, arhs, bhs, rhs, rlhs, pt;
    logic [2:0] eset;
    int mwn, mrn, mstn;
    rand_payload();
    #1;
    awen = (mw < MAXW) && (mst == 0);
    aren = (mr < MAXR) && (mst == 0);
    chk("m_awvalid", m_pcim_awvalid, s_pcim_awvalid && awen);
    chk("s_awready", s_pcim_awready, m_pcim_awready && awen);
    chk("m_arvalid", m_pcim_arvalid, s_pcim_arvalid && aren);
    chk("s_arready", s_pcim_arready, m_pcim_arready && aren);
    pt = (m_pcim_awid === s_pcim_awid) && (m_pcim_awaddr === s_pcim_awaddr) &&
         (m_pcim_awlen === s_pcim_awlen) && (m_pcim_awsize === s_pcim_awsize) &&
         (m_pcim_arid === s_pcim_arid) && (m_pcim_araddr === s_pcim_araddr) &&
         (m_pcim_arlen === s_pcim_arlen) && (m_pcim_arsize === s_pcim_arsize) &&
         (m_pcim_wdata === s_pcim_wdata) && (m_pcim_wstrb === s_pcim_wstrb) &&
         (m_pcim_wlast === s_pcim_wlast) && (m_pcim_wvalid === s_pcim_wvalid) &&
         (s_pcim_wready === m_pcim_wready) &&
         (s_pcim_bid === m_pcim_bid) && (s_pcim_bresp === m_pcim_bresp) &&
         (s_pcim_bvalid === m_pcim_bvalid) && (m_pcim_bready === s_pcim_bready) &&
         (s_pcim_rid === m_pcim_rid) && (s_pcim_rdata === m_pcim_rdata) &&
         (s_pcim_rresp === m_pcim_rresp) && (s_pcim_rlast === m_pcim_rlast) &&
         (s_pcim_rvalid === m_pcim_rvalid) && (m_pcim_rready === s_pcim_rready);
    chk("passthrough", pt, 1);

    awhs = s_pcim_awvalid && awen && m_pcim_awready;
    arhs = s_pcim_arvalid && aren && m_pcim_arready;
    bhs  = m_pcim_bvalid && s_pcim_bready;
    rhs  = m_pcim_rvalid && s_pcim_rready;
    rlhs = rhs && m_pcim_rlast;
    eset = {(bhs && mw == 0) || (rlhs && mr == 0), rhs && m_pcim_rresp != 0, bhs && m_pcim_bresp != 0};
    mwn = (awhs && bhs) ? mw : mw + int'(awhs) - int'(bhs);
    mrn = (arhs && rlhs) ? mr : mr + int'(arhs) - int'(rlhs);
    if (mwn < 0) mwn = 0;
    if (mrn < 0) mrn = 0;
    mstn = mst;
    if (mst == 0 && drain_req) mstn = (mw == 0 && mr == 0 && !awhs && !arhs) ? 2 : 1;
    else if (mst == 1) mstn = !drain_req ? 0 : (mw == 0 && mr == 0) ? 2 : 1;
    else if (mst == 2 && !drain_req) mstn = 0;
    mdrained = (mst == 2);
    merr = (err_clr ? 3'b000 : merr) | eset;
    if (err_clr) begin
      mwc = 0; mrc = 0; msc = 0;
    end else begin
      mwc += int'(awhs); mrc += int'(arhs);
      msc += int'((s_pcim_awvalid && !awen) || (s_pcim_arvalid && !aren));
    end
    mw = mwn; mr = mrn; mst = mstn;

    @(posedge aclk);
    @(negedge aclk);
    chk("wr_ost", wr_ost, mw);
    chk("rd_ost", rd_ost, mr);
    chk("err_sticky", err_sticky, merr);
    chk("drained", drained, mdrained);
`ifdef CL_PCIM_OST_STATS_EN
    chk("wr_cmd_cnt", wr_cmd_cnt, mwc);
    chk("rd_cmd_cnt", rd_cmd_cnt, mrc);
    chk("stall_cnt", stall_cnt, msc);
`endif
  endtask

  initial begin
    idle();
    rand_payload();
    s_pcim_wvalid = 0;
    mreset();
    aresetn = 1'b0;
    #2;
    chk("rst_wr_ost", wr_ost, 0);
    chk("rst_rd_ost", rd_ost, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_drained", drained, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // write limit: 4 pass, 5th held until a B returns
    s_pcim_awvalid = 1;
    repeat (6) tick();
    chk("aw_limit_wr_ost", wr_ost, 4);
    chk("aw5_blocked", m_pcim_awvalid, 0);
    m_pcim_bvalid = 1;
    tick();
    m_pcim_bvalid = 0;
    #1 chk("aw5_passes", m_pcim_awvalid, 1);
    tick();
    chk("aw5_wr_ost", wr_ost, 4);
    s_pcim_awvalid = 0;
    m_pcim_bvalid = 1;
    repeat (4) tick();
    m_pcim_bvalid = 0;
    chk("b_return_wr_ost", wr_ost, 0);

    // AR and R-last in the same cycle leave the count alone
    s_pcim_arvalid = 1;
    repeat (3) tick();
    m_pcim_rvalid = 1; m_pcim_rlast = 1;
    tick();
    chk("ar_rlast_same_cycle", rd_ost, 3);
    s_pcim_arvalid = 0; m_pcim_rlast = 0;
    tick();
    m_pcim_rlast = 1;
    tick();
    m_pcim_rvalid = 0;
    chk("two_reads_ost", rd_ost, 2);

    // drain with two reads outstanding
    drain_req = 1;
    tick();
    s_pcim_awvalid = 1; s_pcim_arvalid = 1;
    #1 chk("drain_aw_gated", m_pcim_awvalid, 0);
    chk("drain_ar_gated", m_pcim_arvalid, 0);
    tick();
    m_pcim_rvalid = 1; m_pcim_rlast = 1;
    repeat (2) tick();
    m_pcim_rvalid = 0;
    tick();
    chk("drained_lags", drained, 0);
    tick();
    chk("drained_set", drained, 1);
    drain_req = 0;
    tick();
    #1 chk("active_after_drain", m_pcim_awvalid, 1);
    s_pcim_awvalid = 0; s_pcim_arvalid = 0;
    tick();

    // error sticky bits
    s_pcim_awvalid = 1;
    tick();
    s_pcim_awvalid = 0;
    m_pcim_bvalid = 1; m_pcim_bresp = 2'b10;
    tick();
    chk("bresp_err", err_sticky, 3'b001);
    m_pcim_bresp = 2'b00;
    tick();
    chk("spurious_b_err", err_sticky, 3'b101);
    chk("spurious_b_wr_ost", wr_ost, 0);
    m_pcim_bvalid = 0; err_clr = 1;
    tick();
    chk("err_clr", err_sticky, 3'b000);
    err_clr = 0; m_pcim_bvalid = 1;
    tick();
    m_pcim_bvalid = 0; s_pcim_awvalid = 1;
    tick();
    s_pcim_awvalid = 0; err_clr = 1; m_pcim_bvalid = 1; m_pcim_bresp = 2'b11;
    tick();
    chk("set_wins_clr", err_sticky, 3'b001);
    idle();
    tick();

    // reset mid-flight
    s_pcim_awvalid = 1; s_pcim_arvalid = 1;
    repeat (3) tick();
    s_pcim_awvalid = 0;
    repeat (2) tick();
    chk("pre_rst_wr", wr_ost, 3);
    chk("pre_rst_rd", rd_ost, 5);
    s_pcim_arvalid = 0;
    #2 aresetn = 1'b0;
    #1;
    mreset();
    chk("async_rst_wr", wr_ost, 0);
    chk("async_rst_rd", rd_ost, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    s_pcim_awvalid = 1;
    tick();
    chk("aw_after_rst", wr_ost, 1);
    s_pcim_awvalid = 0;
    m_pcim_bvalid = 1;
    tick();
    idle();

`ifdef CL_PCIM_OST_STATS_EN
    err_clr = 1;
    tick();
    err_clr = 0;
    for (int i = 0; i < 10; i++) begin
      s_pcim_awvalid = 1; s_pcim_arvalid = (i < 7);
      m_pcim_bvalid = (mw > 0); m_pcim_rvalid = (mr > 0); m_pcim_rlast = 1;
      tick();
    end
    idle();
    drain_req = 1;
    tick();
    s_pcim_awvalid = 1;
    repeat (3) tick();
    chk("stat_wr_cmd", wr_cmd_cnt, 10);
    chk("stat_rd_cmd", rd_cmd_cnt, 7);
    chk("stat_stall", stall_cnt, 3);
    idle();
    m_pcim_bvalid = (mw > 0); m_pcim_rvalid = (mr > 0); m_pcim_rlast = 1;
    tick();
    idle();
    tick();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s_pcim_awvalid = 1'($urandom); s_pcim_arvalid = 1'($urandom);
      s_pcim_wvalid = 1'($urandom); s_pcim_wlast = 1'($urandom);
      m_pcim_awready = 1'($urandom); m_pcim_arready = 1'($urandom); m_pcim_wready = 1'($urandom);
      m_pcim_bvalid = ($urandom_range(0, 2) == 0); s_pcim_bready = 1'($urandom);
      m_pcim_rvalid = ($urandom_range(0, 2) == 0); s_pcim_rready = 1'($urandom);
      m_pcim_rlast = 1'($urandom);
      m_pcim_bresp = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      m_pcim_rresp = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
